// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit
// ID-stage resolver for BEQ/BNE. It holds the IF-stage predictor's decision
// for the branch now in ID, compares the forwarded operands, and on a
// mispredict issues a same-cycle flush/redirect. A sticky flag tells the
// predictor about the miss on its next real branch fetch. Saturating
// branch/miss counters support predictor experiments.
module branch_resolve_unit #(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic [5:0]        if_opcode,
    input  logic              if_pred_taken,
    input  logic [ADDR_W-1:0] if_pc_plus4,
    input  logic [ADDR_W-1:0] if_target,
    input  logic [31:0]       id_rs_data,
    input  logic [31:0]       id_rt_data,
    input  logic              id_ready,
    output logic              pred_wrong,
    output logic              stall_req,
    output logic              flush_if,
    output logic              redirect_valid,
    output logic [ADDR_W-1:0] redirect_pc,
    output logic [CNT_W-1:0]  branch_cnt,
    output logic [CNT_W-1:0]  miss_cnt
);

    localparam logic [5:0]       OP_BEQ  = 6'b000100;
    localparam logic [5:0]       OP_BNE  = 6'b000101;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == CNT_MAX) begin
            sat_inc = v;
        end else begin
            sat_inc = v + CNT_ONE;
        end
    endfunction

    // Pending branch entry (the branch currently in ID)
    logic              p_valid;
    logic              p_taken;
    logic              p_bne;
    logic [ADDR_W-1:0] p_pc4;
    logic [ADDR_W-1:0] p_tgt;
    logic              wrong_r;
    logic [CNT_W-1:0]  branch_cnt_r;
    logic [CNT_W-1:0]  miss_cnt_r;

    logic if_is_branch;
    logic resolve;
    logic actual;
    logic miss;
    logic capture;

    // Decode the IF branch and resolve the pending branch against operands.
    always_comb begin
        if_is_branch = (if_opcode == OP_BEQ) || (if_opcode == OP_BNE);
        resolve      = p_valid & id_ready & ~stall;
        actual       = (id_rs_data == id_rt_data) ^ p_bne;
        miss         = resolve & (actual != p_taken);
        // A flushed IF instruction is wrong-path: never captured or consuming.
        capture      = if_is_branch & ~stall & ~miss;
    end

    // Drive hazard, flush/redirect and predictor-feedback outputs.
    always_comb begin
        stall_req      = p_valid & ~id_ready;
        flush_if       = miss;
        redirect_valid = miss;
        pred_wrong     = wrong_r & ~miss;
        if (miss) begin
            redirect_pc = actual ? p_tgt : p_pc4;
        end else begin
            redirect_pc = {ADDR_W{1'b0}};
        end
        branch_cnt = branch_cnt_r;
        miss_cnt   = miss_cnt_r;
    end

    // Pending entry: capture wins over release; otherwise hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            p_valid <= 1'b0;
            p_taken <= 1'b0;
            p_bne   <= 1'b0;
            p_pc4   <= {ADDR_W{1'b0}};
            p_tgt   <= {ADDR_W{1'b0}};
        end else if (capture) begin
            p_valid <= 1'b1;
            p_taken <= if_pred_taken;
            p_bne   <= (if_opcode == OP_BNE);
            p_pc4   <= if_pc_plus4;
            p_tgt   <= if_target;
        end else if (resolve) begin
            p_valid <= 1'b0;
        end else begin
            p_valid <= p_valid;
        end
    end

    // Sticky mispredict flag: a new miss outranks consumption by the predictor.
    always_ff @(posedge clk) begin
        if (rst) begin
            wrong_r <= 1'b0;
        end else if (miss) begin
            wrong_r <= 1'b1;
        end else if (capture) begin
            wrong_r <= 1'b0;
        end else begin
            wrong_r <= wrong_r;
        end
    end

    // Saturating statistics; miss implies resolve so miss_cnt never passes branch_cnt.
    always_ff @(posedge clk) begin
        if (rst) begin
            branch_cnt_r <= {CNT_W{1'b0}};
            miss_cnt_r   <= {CNT_W{1'b0}};
        end else begin
            if (resolve) begin
                branch_cnt_r <= sat_inc(branch_cnt_r);
            end else begin
                branch_cnt_r <= branch_cnt_r;
            end
            if (miss) begin
                miss_cnt_r <= sat_inc(miss_cnt_r);
            end else begin
                miss_cnt_r <= miss_cnt_r;
            end
        end
    end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench for branch_resolve_unit. The stimulus process computes
// each cycle's expected outputs from a behavioural model and queues them; a
// negedge monitor pops and compares against two instances (16-bit and 2-bit
// counters, the latter to exercise saturation).
module tb_branch_resolve_unit;

    localparam logic [5:0] BEQ = 6'b000100;
    localparam logic [5:0] BNE = 6'b000101;
    localparam logic [5:0] NOP = 6'b000000;

    logic        clk;
    logic        rst;
    logic        stall;
    logic [5:0]  if_opcode;
    logic        if_pred_taken;
    logic [31:0] if_pc_plus4;
    logic [31:0] if_target;
    logic [31:0] id_rs_data;
    logic [31:0] id_rt_data;
    logic        id_ready;

    logic        pred_wrong, stall_req, flush_if, redirect_valid;
    logic [31:0] redirect_pc;
    logic [15:0] branch_cnt, miss_cnt;

    logic        s_pred_wrong, s_stall_req, s_flush_if, s_redirect_valid;
    logic [31:0] s_redirect_pc;
    logic [1:0]  s_branch_cnt, s_miss_cnt;

    branch_resolve_unit #(.ADDR_W(32), .CNT_W(16)) u_dut (
        .clk(clk), .rst(rst), .stall(stall), .if_opcode(if_opcode),
        .if_pred_taken(if_pred_taken), .if_pc_plus4(if_pc_plus4),
        .if_target(if_target), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
        .id_ready(id_ready), .pred_wrong(pred_wrong), .stall_req(stall_req),
        .flush_if(flush_if), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .branch_cnt(branch_cnt), .miss_cnt(miss_cnt)
    );

    branch_resolve_unit #(.ADDR_W(32), .CNT_W(2)) u_dut_sat (
        .clk(clk), .rst(rst), .stall(stall), .if_opcode(if_opcode),
        .if_pred_taken(if_pred_taken), .if_pc_plus4(if_pc_plus4),
        .if_target(if_target), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
        .id_ready(id_ready), .pred_wrong(s_pred_wrong), .stall_req(s_stall_req),
        .flush_if(s_flush_if), .redirect_valid(s_redirect_valid),
        .redirect_pc(s_redirect_pc), .branch_cnt(s_branch_cnt), .miss_cnt(s_miss_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        pw;
        logic        sr;
        logic        fl;
        logic [31:0] rpc;
        int          bc;
        int          mc;
        int          bc2;
        int          mc2;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    // Reference model state (what the ID stage is holding, in plain terms)
    bit          m_known = 1'b0;
    bit          m_have;
    bit          m_guess_taken;
    bit          m_is_bne;
    logic [31:0] m_fall;
    logic [31:0] m_dest;
    bit          m_owed;
    int          m_branches, m_misses, m_branches2, m_misses2;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    // Apply one cycle of inputs, queue expected outputs, advance the model.
    task automatic cyc(input bit r, input logic [5:0] op, input bit pt,
                       input logic [31:0] pc4, input logic [31:0] tgt,
                       input logic [31:0] rs, input logic [31:0] rt,
                       input bit rdy, input bit stl);
        exp_t e;
        bit   is_br, resolving, really_taken, wrong, fetch_ok;
        rst = r; if_opcode = op; if_pred_taken = pt; if_pc_plus4 = pc4;
        if_target = tgt; id_rs_data = rs; id_rt_data = rt; id_ready = rdy;
        stall = stl;

        is_br        = (op == BEQ) || (op == BNE);
        resolving    = m_have && rdy && !stl;
        really_taken = m_is_bne ? (rs != rt) : (rs == rt);
        wrong        = resolving && (really_taken != m_guess_taken);
        fetch_ok     = is_br && !stl && !wrong;

        e.pw  = m_owed && !wrong;
        e.sr  = m_have && !rdy;
        e.fl  = wrong;
        e.rpc = wrong ? (really_taken ? m_dest : m_fall) : 32'd0;
        e.bc  = m_branches;  e.mc  = m_misses;
        e.bc2 = m_branches2; e.mc2 = m_misses2;
        if (m_known) exp_q.push_back(e);

        if (r) begin
            m_known = 1'b1; m_have = 1'b0; m_owed = 1'b0;
            m_guess_taken = 1'b0; m_is_bne = 1'b0; m_fall = 32'd0; m_dest = 32'd0;
            m_branches = 0; m_misses = 0; m_branches2 = 0; m_misses2 = 0;
        end else begin
            if (resolving) begin
                m_branches  = (m_branches  < 65535) ? m_branches  + 1 : 65535;
                m_branches2 = (m_branches2 < 3)     ? m_branches2 + 1 : 3;
                m_have = 1'b0;
            end
            if (wrong) begin
                m_misses  = (m_misses  < 65535) ? m_misses  + 1 : 65535;
                m_misses2 = (m_misses2 < 3)     ? m_misses2 + 1 : 3;
                m_owed = 1'b1;
            end else if (fetch_ok) begin
                m_owed = 1'b0;
            end
            if (fetch_ok) begin
                m_have = 1'b1; m_guess_taken = pt; m_is_bne = (op == BNE);
                m_fall = pc4; m_dest = tgt;
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare the DUT's presented outputs with the queued expectation.
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("pred_wrong",     {63'd0, pred_wrong},     {63'd0, e.pw});
            chk("stall_req",      {63'd0, stall_req},      {63'd0, e.sr});
            chk("flush_if",       {63'd0, flush_if},       {63'd0, e.fl});
            chk("redirect_valid", {63'd0, redirect_valid}, {63'd0, e.fl});
            chk("redirect_pc",    {32'd0, redirect_pc},    {32'd0, e.rpc});
            chk("branch_cnt",     {48'd0, branch_cnt},     64'(e.bc));
            chk("miss_cnt",       {48'd0, miss_cnt},       64'(e.mc));
            chk("sat_pred_wrong", {63'd0, s_pred_wrong},   {63'd0, e.pw});
            chk("sat_stall_req",  {63'd0, s_stall_req},    {63'd0, e.sr});
            chk("sat_flush_if",   {63'd0, s_flush_if | s_redirect_valid}, {63'd0, e.fl});
            chk("sat_redirect_pc",{32'd0, s_redirect_pc},  {32'd0, e.rpc});
            chk("sat_branch_cnt", {62'd0, s_branch_cnt},   64'(e.bc2));
            chk("sat_miss_cnt",   {62'd0, s_miss_cnt},     64'(e.mc2));
        end
    end

    initial begin
        int          drain;
        bit          rnd_stall, rdy;
        logic [5:0]  op;
        logic [31:0] a, b;

        // Reset for two cycles with a BEQ sitting in IF
        cyc(1'b1, BEQ, 1'b1, 32'h10, 32'h40, 32'd0, 32'd0, 1'b1, 1'b0);
        cyc(1'b1, BEQ, 1'b1, 32'h10, 32'h40, 32'd0, 32'd0, 1'b1, 1'b0);
        cyc(1'b0, NOP, 1'b0, 32'h0, 32'h0, 32'd0, 32'd0, 1'b1, 1'b0);

        // BEQ predicted not-taken but taken: redirect to 0x200, flag sticks
        cyc(1'b0, BEQ, 1'b0, 32'h104, 32'h200, 32'd0, 32'd0, 1'b1, 1'b0);
        cyc(1'b0, NOP, 1'b0, 32'h0, 32'h0, 32'd5, 32'd5, 1'b1, 1'b0);
        cyc(1'b0, NOP, 1'b0, 32'h0, 32'h0, 32'd1, 32'd2, 1'b1, 1'b0);
        cyc(1'b0, NOP, 1'b0, 32'h0, 32'h0, 32'd1, 32'd2, 1'b1, 1'b0);
        cyc(1'b0, BEQ, 1'b0, 32'h304, 32'h400, 32'd1, 32'd2, 1'b1, 1'b1);
        cyc(1'b0, BEQ, 1'b0, 32'h304, 32'h400, 32'd1, 32'd2, 1'b1, 1'b0);
        cyc(1'b0, NOP, 1'b0, 32'h0, 32'h0, 32'd1, 32'd2, 1'b1, 1'b0);

        // BNE predicted taken, operands differ: correct, no redirect
        cyc(1'b0, BNE, 1'b1, 32'h504, 32'h600, 32'd0, 32'd0, 1'b1, 1'b0);
        cyc(1'b0, NOP, 1'b0, 32'h0, 32'h0, 32'd3, 32'd7, 1'b1, 1'b0);

        // Operand hazard: three not-ready cycles with the hazard stall, then resolve
        cyc(1'b0, BEQ, 1'b1, 32'h704, 32'h800, 32'd0, 32'd0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++)
            cyc(1'b0, BNE, 1'b0, 32'h904, 32'hA00, 32'd9, 32'd9, 1'b0, 1'b1);
        cyc(1'b0, NOP, 1'b0, 32'h0, 32'h0, 32'd9, 32'd9, 1'b1, 1'b0);

        // Back-to-back, first correct: BNE captured as BEQ resolves
        cyc(1'b0, BEQ, 1'b0, 32'hB04, 32'hC00, 32'd0, 32'd0, 1'b1, 1'b0);
        cyc(1'b0, BNE, 1'b0, 32'hD04, 32'hE00, 32'd1, 32'd2, 1'b1, 1'b0);
        cyc(1'b0, NOP, 1'b0, 32'h0, 32'h0, 32'd4, 32'd4, 1'b1, 1'b0);

        // Back-to-back, first mispredicts: the BNE is flushed, never captured
        cyc(1'b0, BEQ, 1'b0, 32'hF04, 32'h1000, 32'd0, 32'd0, 1'b1, 1'b0);
        cyc(1'b0, BNE, 1'b1, 32'h1104, 32'h1200, 32'd6, 32'd6, 1'b1, 1'b0);
        cyc(1'b0, NOP, 1'b0, 32'h0, 32'h0, 32'd6, 32'd7, 1'b1, 1'b0);
        cyc(1'b0, NOP, 1'b0, 32'h0, 32'h0, 32'd6, 32'd7, 1'b1, 1'b0);

        // Randomised traffic with a hazard-unit style stall
        for (int n = 0; n < 3000; n++) begin
            case ($urandom_range(0, 3))
                0:       op = BEQ;
                1:       op = BNE;
                default: op = 6'($urandom_range(0, 63));
            endcase
            a = 32'($urandom_range(0, 3));
            b = ($urandom_range(0, 1) == 0) ? a : 32'($urandom);
            rdy       = ($urandom_range(0, 3) != 0);
            rnd_stall = ($urandom_range(0, 7) == 0);
            cyc(($urandom_range(0, 199) == 0), op, 1'($urandom),
                32'($urandom), 32'($urandom), a, b, rdy,
                rnd_stall || (m_have && !rdy));
        end

        // Let the monitor drain the queue, bounded
        drain = 0;
        while (exp_q.size() > 0 && drain < 10) begin
            @(posedge clk);
            drain++;
        end
        n_vec++;
        if (exp_q.size() != 0) begin
            n_miss++;
            $display("FAIL drain: got %0d queued expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
